// File: rtl/anfsqrt_square.sv
// anfsqrt_square: iterative shift-and-add squarer with valid/ready handshakes on both sides.
// Optional ANFSQRT_SQUARE_REM_EN adds a `rem` port that preloads the accumulator (x*x + rem).
module anfsqrt_square (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  root,
`ifdef ANFSQRT_SQUARE_REM_EN
   input  logic [7:0]  rem,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] result
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   state_t      r_state;
   logic [13:0] r_mcand;
   logic [13:0] r_acc;
   logic [13:0] r_result;
   logic [6:0]  r_mult;
   logic [2:0]  r_iter;
   logic [13:0] w_pre;
   logic [13:0] w_sum;
`ifdef ANFSQRT_SQUARE_REM_EN
   assign w_pre = {6'd0, rem};
`else
   assign w_pre = 14'd0;
`endif
   // one partial product per cycle; the sum wraps modulo 2^14
   assign w_sum     = r_acc + (r_mult[r_iter] ? r_mcand << r_iter : 14'd0);
   assign in_ready  = r_state == S_IDLE;
   assign out_valid = r_state == S_DONE;
   assign result    = r_result;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mult   <= '0;
         r_acc    <= '0;
         r_iter   <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_mcand <= {7'd0, root};
               r_mult  <= root;
               r_acc   <= w_pre;
               r_iter  <= '0;
               r_state <= S_BUSY;
            end
            S_BUSY: begin
               r_acc  <= w_sum;
               r_iter <= r_iter + 3'd1;
               if (r_iter == 3'd6) begin
                  r_result <= w_sum;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: if (out_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_anfsqrt_square.sv
// tb_anfsqrt_square: directed steps with a scoreboard queue filled on input handshakes
// and drained on output handshakes; works with or without ANFSQRT_SQUARE_REM_EN.
module tb_anfsqrt_square;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  root;
   logic [7:0]  rem;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] result;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          t_acc = 0;
   int          last_acc = 0;
   int          gap = 0;
   logic        ov_d = 1'b0;
   logic [13:0] q[$];

   always #5 clk = ~clk;

   anfsqrt_square dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .root(root),
`ifdef ANFSQRT_SQUARE_REM_EN
      .rem(rem),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result)
   );

   function automatic logic [13:0] model(input logic [6:0] x, input logic [7:0] r);
      int v;
      v = int'(x) * int'(x);
`ifdef ANFSQRT_SQUARE_REM_EN
      v = v + int'(r);
`endif
      return v[13:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("out_timeout", out_valid, 1);
   endtask

   task automatic op(input logic [6:0] x, input logic [7:0] r);
      in_valid = 1'b1;
      root = x;
      rem = r;
      tick();
      in_valid = 1'b0;
      chk("busy_not_ready", in_ready, 0);
      wait_out();
      tick();
      chk("idle_ready", in_ready, 1);
      chk("valid_cleared", out_valid, 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: everything seen here takes effect on the next rising edge
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         ov_d <= 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            q.push_back(model(root, rem));
            gap <= cyc + 1 - last_acc;
            last_acc <= cyc + 1;
            t_acc <= cyc + 1;
         end
         if (out_valid && !ov_d) chk("latency", cyc - t_acc, 7);
         if (out_valid && out_ready) begin
            chk("out_expected", q.size() > 0, 1);
            if (q.size() > 0) chk("result", result, q.pop_front());
         end
         ov_d <= out_valid;
      end
   end

   initial begin
      int n;
      logic seen;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      root = '0;
      rem = '0;
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      rst = 1'b0;
      tick();
      op(7'd0, 8'd0);
      chk("zero_result", result, 0);
`ifdef ANFSQRT_SQUARE_REM_EN
      op(7'd127, 8'd254);
      chk("max_result", result, 16383);
      op(7'd127, 8'd255);
      chk("wrap_result", result, 0);
`else
      op(7'd127, 8'd0);
      chk("max_result", result, 16129);
`endif
      // backpressure
      out_ready = 1'b0;
      in_valid = 1'b1;
      root = 7'd11;
      rem = 8'd0;
      tick();
      in_valid = 1'b0;
      wait_out();
      repeat (20) begin
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_result", result, 121);
         chk("bp_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      // back-to-back with operand changed while busy
      in_valid = 1'b1;
      root = 7'd5;
      tick();
      root = 7'd9;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk("b2b_ready_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("b2b_gap", gap, 9);
      wait_out();
      chk("b2b_second", result, 81);
      tick();
      // reset during busy
      in_valid = 1'b1;
      root = 7'd100;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_result", result, 0);
      seen = 1'b0;
      repeat (10) begin
         tick();
         seen = seen | out_valid;
      end
      chk("mid_rst_no_out", seen, 0);
      op(7'd3, 8'd0);
      chk("after_rst", result, 9);
      // sweep
      for (int x = 0; x < 128; x++) begin
`ifdef ANFSQRT_SQUARE_REM_EN
         op(7'(x), 8'd0);
         op(7'(x), 8'(2 * x));
         op(7'(x), 8'($urandom_range(0, 2 * x)));
`else
         op(7'(x), 8'd0);
`endif
      end
      tick();
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/anfsqrt_square.md
# anfsqrt_square

Clocked iterative squarer, the inverse of the ANF square-root unit. It takes a 7-bit root and returns its 14-bit square, computing one partial product per cycle with shift-and-add. Unlike the free-running root unit, it has valid/ready handshakes on both sides. It sits downstream of the root unit for reconstruction and self-check paths: root in, original query out.

## Interface
Parameters: none; widths are fixed at 7-bit operand and 14-bit result.

- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high; sampled on rising edge of clk
- in_valid  in  1  operand present on `root` (and `rem` when compiled in)
- in_ready  out  1  block can accept an operand; high only in IDLE
- root  in  7  unsigned operand x
- rem  in  8  unsigned addend; present only with ANFSQRT_SQUARE_REM_EN
- out_valid  out  1  `result` holds a completed square
- out_ready  in  1  consumer accepts `result`
- result  out  14  x*x (+ rem when compiled in), modulo 2^14

## Operation
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE
  - in_ready = 1.
  - On a rising edge with in_valid=1, the block latches: mcand = root, zero-extended to 14 bits; mult = root; acc = rem, or 0 without the macro; iter = 0. It then goes to BUSY.
- BUSY
  - in_ready = 0; in_valid and operand changes are ignored.
  - Each edge: if mult[iter]=1, then acc <= acc + (mcand << iter), truncated to 14 bits. Then iter <= iter + 1.
  - iter is 3 bits and runs 0..6.
  - On the edge that processes iter=6: result <= the final sum, out_valid <= 1, state -> DONE.
- DONE
  - out_valid = 1; result is held stable.
  - On an edge with out_ready=1: out_valid <= 0, state -> IDLE.
  - out_ready=0 stalls indefinitely without data change.
- result updates only on completion. It keeps its value after the handshake until the next completion.
- Arithmetic
  - Unsigned throughout; no signed interpretation.
  - Without the macro, the maximum is 127² = 16129, so there is no overflow.
  - With the macro, any valid sqrt remainder (rem ≤ 2x) gives at most 16383, so it fits.
  - rem > 2x is legal input; the sum wraps modulo 2^14.
- No overlap: a new operand cannot be accepted in the same cycle as the output handshake.

## Timing
- Reset values (after the first rising edge with rst=1): state=IDLE, in_ready=1, out_valid=0, result=0, acc=0, iter=0.
- rst overrides everything, including mid-BUSY and mid-DONE. The operation in flight is discarded and no out_valid pulse is produced.
- Latency: input handshake on edge N. out_valid rises after edge N+7, i.e. 7 BUSY cycles.
- Minimum period per operation: 9 cycles (1 IDLE accept + 7 BUSY + 1 DONE), with out_ready held high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- When state=IDLE and rst=0, an in_valid sampled high is accepted on that edge.

## Configuration
- Macro: ANFSQRT_SQUARE_REM_EN.
- Defined:
  - `rem` port exists; acc is preloaded with rem on accept.
  - result = x² + rem mod 2^14, which reconstructs the original query from (root, remainder).
- Undefined:
  - `rem` port is absent and acc is preloaded with 0.
  - result = x².
  - Handshake and timing are unchanged.

## Test plan
- Reset, then root=0 with in_valid for one cycle, out_ready=1 -> out_valid after 7 cycles, result=0, then back to IDLE with in_ready=1.
- root=127, out_ready=1 -> result=16129 (0x3F01) exactly 7 cycles after accept. With the macro and rem=254 -> result=16383 (0x3FFF).
- Backpressure: root=11 with out_ready=0 for 20 cycles -> out_valid stays 1, result stays 121, in_ready stays 0. Raising out_ready completes the handshake next edge.
- Back-to-back: in_valid held high with root=5, then root=9, out_ready=1 -> results 25 then 81. Second accept no earlier than 9 cycles after the first; operand changes during BUSY are ignored.
- rst asserted on the 4th BUSY cycle of root=100 -> no out_valid. After reset, result=0 and in_ready=1; a new root=3 gives 9.
- Exhaustive sweep of root 0..127 (with the macro: rem 0..2·root) -> every result equals x²(+rem), checked against a model.
